// File: rtl/led_playback_sequencer.sv
// Plays stored colour codes from sequence memory onto four LEDs with on/gap timing.
// Optional PLAYBACK_FLASH_EN adds a flash_req input and an all-LED flash state.
module led_playback_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 2,
    parameter int unsigned FAST_ON_CYCLES = 25_000_000,
    parameter int unsigned SLOW_ON_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 12_500_000,
    parameter int unsigned FLASH_CYCLES   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play_req,
    input  logic [ADDR_WIDTH-1:0] play_last,
    input  logic                  speed,
    input  logic                  abort,
`ifdef PLAYBACK_FLASH_EN
    input  logic                  flash_req,
`endif
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  led_red,
    output logic                  led_green,
    output logic                  led_blue,
    output logic                  led_yellow,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned MAX_ON     = (FAST_ON_CYCLES > SLOW_ON_CYCLES) ?
                                         FAST_ON_CYCLES : SLOW_ON_CYCLES;
    localparam int unsigned MAX_OFF    = (GAP_CYCLES > FLASH_CYCLES) ? GAP_CYCLES : FLASH_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_ON > MAX_OFF) ? MAX_ON : MAX_OFF;
    localparam int unsigned TIMER_WIDTH = $clog2(MAX_CYCLES) + 1;

    // Zero-length parameters are clamped to one cycle.
    localparam int unsigned FAST_N  = (FAST_ON_CYCLES == 0) ? 1 : FAST_ON_CYCLES;
    localparam int unsigned SLOW_N  = (SLOW_ON_CYCLES == 0) ? 1 : SLOW_ON_CYCLES;
    localparam int unsigned GAP_N   = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned FLASH_N = (FLASH_CYCLES == 0) ? 1 : FLASH_CYCLES;

    localparam logic [TIMER_WIDTH-1:0] FAST_LOAD  = TIMER_WIDTH'(FAST_N - 1);
    localparam logic [TIMER_WIDTH-1:0] SLOW_LOAD  = TIMER_WIDTH'(SLOW_N - 1);
    localparam logic [TIMER_WIDTH-1:0] GAP_LOAD   = TIMER_WIDTH'(GAP_N - 1);
`ifdef PLAYBACK_FLASH_EN
    localparam logic [TIMER_WIDTH-1:0] FLASH_LOAD = TIMER_WIDTH'(FLASH_N - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StOn,
        StGap,
        StDone
`ifdef PLAYBACK_FLASH_EN
        , StFlash
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   last_q, last_d;
    logic                    speed_q, speed_d;
    logic [DATA_WIDTH-1:0]   colour_q, colour_d;
    logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
    logic [3:0]              leds;
    logic                    timer_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            last_q   <= '0;
            speed_q  <= 1'b0;
            colour_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            speed_q  <= speed_d;
            colour_q <= colour_d;
            timer_q  <= timer_d;
        end
    end

    assign timer_zero = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        speed_d  = speed_q;
        colour_d = colour_q;
        timer_d  = timer_q;
        mem_rd   = 1'b0;
        mem_addr = idx_q;
        leds     = 4'b0000;
        busy     = 1'b1;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy     = 1'b0;
                mem_addr = '0;
                if (play_req) begin
                    last_d  = play_last;
                    speed_d = speed;
                    idx_d   = '0;
                    state_d = StFetch;
                end
`ifdef PLAYBACK_FLASH_EN
                else if (flash_req) begin
                    idx_d   = '0;
                    timer_d = FLASH_LOAD;
                    state_d = StFlash;
                end
`endif
            end
            StFetch: begin
                mem_rd  = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                colour_d = mem_data;
                timer_d  = speed_q ? FAST_LOAD : SLOW_LOAD;
                state_d  = StOn;
            end
            StOn: begin
                leds = 4'b0001 << colour_q;
                if (timer_zero) begin
                    timer_d = GAP_LOAD;
                    state_d = StGap;
                end else begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end
            end
            StGap: begin
                if (!timer_zero) begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end else if (idx_q == last_q) begin
                    // Compare before incrementing so the top address never wraps to 0.
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = StFetch;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
`ifdef PLAYBACK_FLASH_EN
            StFlash: begin
                leds = 4'b1111;
                if (timer_zero) begin
                    state_d = StDone;
                end else begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d = StIdle;
        end
    end

    assign led_red    = leds[0];
    assign led_green  = leds[1];
    assign led_blue   = leds[2];
    assign led_yellow = leds[3];

endmodule
